// File: rtl/multiphase_mtr_drv_if.sv
// rtl/multiphase_mtr_drv_if.sv - command/status bundle between commutation logic and gate driver
interface multiphase_mtr_drv_if #(
  parameter int NUM_PH = 3,
  parameter int DUTY_W = 11,
  parameter int DT_W   = 5
);
  logic [DUTY_W-1:0]   duty;
  logic [2*NUM_PH-1:0] sel;
  logic [DT_W-1:0]     dead_time;
  logic                fault;
  logic                clr_fault;
  logic                PWM_synch;
  logic [NUM_PH-1:0]   high;
  logic [NUM_PH-1:0]   low;
  logic                fault_latched;

  modport master (
    output duty, sel, dead_time, fault, clr_fault,
    input  PWM_synch, high, low, fault_latched
  );

  modport slave (
    input  duty, sel, dead_time, fault, clr_fault,
    output PWM_synch, high, low, fault_latched
  );
endinterface

// File: rtl/multiphase_mtr_drv.sv
// rtl/multiphase_mtr_drv.sv - N-phase gate driver: shadowed PWM, select decode, dead time, fault latch
module multiphase_mtr_drv #(
  parameter int NUM_PH = 3,
  parameter int DUTY_W = 11,
  parameter int DT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  multiphase_mtr_drv_if.slave  bus
);

  logic [DUTY_W-1:0]            cnt_q, cnt_d;
  logic [DUTY_W-1:0]            duty_q, duty_d;
  logic                         synch_q, synch_d;
  logic                         fault_latched_q, fault_latched_d;
  logic [NUM_PH-1:0]            hi_q, hi_d, lo_q, lo_d;
  logic [NUM_PH-1:0]            high_q, high_d, low_q, low_d;
  logic [NUM_PH-1:0][DT_W-1:0]  dt_q, dt_d;

  logic              wrap;
  logic              pwm;
  logic              clr_ok;
  logic              blank;
  logic [NUM_PH-1:0] hi_in, lo_in;

  always_comb begin
    wrap    = &cnt_q;
    cnt_d   = cnt_q + 1'b1;
    synch_d = wrap;
    duty_d  = wrap ? bus.duty : duty_q;
    pwm     = (cnt_q < duty_q);

    // A clear only counts when a fault is actually latched and the fault line is quiet.
    clr_ok          = bus.clr_fault & ~bus.fault & fault_latched_q;
    blank           = bus.fault | fault_latched_q;
    fault_latched_d = bus.fault | (fault_latched_q & ~clr_ok);

    hi_in  = '0;
    lo_in  = '0;
    high_d = '0;
    low_d  = '0;
    dt_d   = dt_q;
    for (int i = 0; i < NUM_PH; i++) begin
      case (bus.sel[2*i +: 2])
        2'b01: begin
          hi_in[i] = ~pwm;
          lo_in[i] = pwm;
        end
        2'b10: begin
          hi_in[i] = pwm;
          lo_in[i] = ~pwm;
        end
        2'b11: lo_in[i] = pwm;
        default: ;
      endcase

      // Any change of the requested gate pair restarts the blanking interval.
      if ({hi_in[i], lo_in[i]} != {hi_q[i], lo_q[i]}) begin
        dt_d[i] = bus.dead_time;
      end else if (dt_q[i] != '0) begin
        dt_d[i] = dt_q[i] - 1'b1;
      end else begin
        high_d[i] = hi_q[i];
        low_d[i]  = lo_q[i];
      end

      if (clr_ok) begin
        dt_d[i] = bus.dead_time;
      end
      if (blank) begin
        high_d[i] = 1'b0;
        low_d[i]  = 1'b0;
      end
    end

    hi_d = hi_in;
    lo_d = lo_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q           <= '0;
      duty_q          <= '0;
      synch_q         <= 1'b0;
      fault_latched_q <= 1'b0;
      hi_q            <= '0;
      lo_q            <= '0;
      high_q          <= '0;
      low_q           <= '0;
      dt_q            <= '0;
    end else begin
      cnt_q           <= cnt_d;
      duty_q          <= duty_d;
      synch_q         <= synch_d;
      fault_latched_q <= fault_latched_d;
      hi_q            <= hi_d;
      lo_q            <= lo_d;
      high_q          <= high_d;
      low_q           <= low_d;
      dt_q            <= dt_d;
    end
  end

  assign bus.PWM_synch     = synch_q;
  assign bus.high          = high_q;
  assign bus.low           = low_q;
  assign bus.fault_latched = fault_latched_q;

endmodule
